// File: rtl/neopix_rx.sv
// WS2812B single-wire receiver: synchronizes din, measures high-pulse widths,
// assembles 24-bit pixels MSB-first and flags frame gaps and malformed pulses.
// Intended parameter ordering: HMIN < THRESH <= HMAX < RES.
module neopix_rx #(
    parameter int HMIN   = 3,
    parameter int THRESH = 10,
    parameter int HMAX   = 20,
    parameter int RES    = 850,
    parameter int IDX_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic             bit_error
);

    localparam int LOW_W  = $clog2(RES + 1);
    localparam int HIGH_W = $clog2(HMAX + 2);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    logic             din_meta_r;
    logic             din_sync_r;
    logic             din_s;
    state_t           state_r,    state_nx_s;
    logic [LOW_W-1:0] low_cnt_r,  low_nx_s;
    logic [HIGH_W-1:0] high_cnt_r, high_nx_s;
    logic [4:0]       bit_cnt_r,  bit_nx_s;
    logic [23:0]      shift_r,    shift_nx_s;
    logic             pix_done_s, pix_done_r;
    logic             frame_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_r;

    assign din_s = din_sync_r;

    // Two-flop synchronizer for the asynchronous data line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta_r <= 1'b0;
            din_sync_r <= 1'b0;
        end else begin
            din_meta_r <= din;
            din_sync_r <= din_meta_r;
        end
    end

    // Next-state logic: SYNC waits for a full gap, HIGH measures, IDLE times lows.
    always_comb begin
        state_nx_s = state_r;
        low_nx_s   = low_cnt_r;
        high_nx_s  = high_cnt_r;
        bit_nx_s   = bit_cnt_r;
        shift_nx_s = shift_r;
        pix_done_s = 1'b0;
        frame_s    = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (din_s) begin
                    low_nx_s = {LOW_W{1'b0}};
                end else begin
                    low_nx_s = low_cnt_r + LOW_W'(1);
                    if (low_cnt_r == LOW_W'(RES - 1)) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_SYNC;
                    end
                end
            end
            ST_IDLE: begin
                if (din_s) begin
                    state_nx_s = ST_HIGH;
                    high_nx_s  = HIGH_W'(1);
                    low_nx_s   = {LOW_W{1'b0}};
                end else if (low_cnt_r != LOW_W'(RES)) begin
                    low_nx_s = low_cnt_r + LOW_W'(1);
                    // The gap fires only on the transition into saturation.
                    if (low_cnt_r == LOW_W'(RES - 1)) begin
                        frame_s  = 1'b1;
                        err_s    = (bit_cnt_r != 5'd0);
                        bit_nx_s = 5'd0;
                    end else begin
                        frame_s  = 1'b0;
                    end
                end else begin
                    low_nx_s = low_cnt_r;
                end
            end
            ST_HIGH: begin
                if (din_s) begin
                    if (high_cnt_r != HIGH_W'(HMAX + 1)) begin
                        high_nx_s = high_cnt_r + HIGH_W'(1);
                    end else begin
                        high_nx_s = high_cnt_r;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                    low_nx_s   = LOW_W'(1);
                    if ((high_cnt_r < HIGH_W'(HMIN)) || (high_cnt_r > HIGH_W'(HMAX))) begin
                        err_s    = 1'b1;
                        bit_nx_s = 5'd0;
                    end else begin
                        shift_nx_s = {shift_r[22:0], (high_cnt_r >= HIGH_W'(THRESH))};
                        if (bit_cnt_r == 5'd23) begin
                            bit_nx_s   = 5'd0;
                            pix_done_s = 1'b1;
                        end else begin
                            bit_nx_s   = bit_cnt_r + 5'd1;
                        end
                    end
                end
            end
            default: begin
                state_nx_s = ST_SYNC;
                low_nx_s   = {LOW_W{1'b0}};
            end
        endcase
    end

    // Decoder state and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_SYNC;
            low_cnt_r  <= {LOW_W{1'b0}};
            high_cnt_r <= {HIGH_W{1'b0}};
            bit_cnt_r  <= 5'd0;
            shift_r    <= 24'd0;
            pix_done_r <= 1'b0;
            frame_done <= 1'b0;
            bit_error  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            low_cnt_r  <= low_nx_s;
            high_cnt_r <= high_nx_s;
            bit_cnt_r  <= bit_nx_s;
            shift_r    <= shift_nx_s;
            pix_done_r <= pix_done_s;
            frame_done <= frame_s;
            bit_error  <= err_s;
        end
    end

    // Pixel output stage; idx_r holds the index the next pixel will carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data  <= 24'd0;
            pixel_valid <= 1'b0;
            pixel_index <= {IDX_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
        end else begin
            pixel_valid <= pix_done_r;
            if (pix_done_r) begin
                pixel_data  <= shift_r;
                pixel_index <= idx_r;
                idx_r       <= idx_r + IDX_W'(1);
            end else if (frame_s) begin
                pixel_index <= {IDX_W{1'b0}};
                idx_r       <= {IDX_W{1'b0}};
            end else begin
                idx_r       <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_neopix_rx.sv
// Directed bench for neopix_rx: drives NZR pulses on negedges and checks
// pixels, indices, frame gaps and error strobes against hand-computed values.
module tb_neopix_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic        bit_error;

    int nvec = 0;
    int nerr = 0;

    int pv_cnt = 0;
    int fd_cnt = 0;
    int be_cnt = 0;
    int fdbe_cnt = 0;
    logic [23:0] data_log [64];
    logic [7:0]  idx_log  [64];

    neopix_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .bit_error   (bit_error)
    );

    always #5 clk = ~clk;

    // Event monitor sampled mid-high-phase so the negedge driver sees settled counts.
    always @(posedge clk) begin
        #2;
        if (pixel_valid === 1'b1) begin
            if (pv_cnt < 64) begin
                data_log[pv_cnt] = pixel_data;
                idx_log[pv_cnt]  = pixel_index;
            end
            pv_cnt++;
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (bit_error === 1'b1) be_cnt++;
        if ((frame_done === 1'b1) && (bit_error === 1'b1)) fdbe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Sends the low n bits of v, most significant first.
    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i]) send_pulse(13, 7);
            else      send_pulse(6, 14);
        end
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        int fd_b;
        int be_b;
        int fdbe_b;
        logic [23:0] px;

        din   = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data",  32'(pixel_data),  32'd0);
        check("rst_index", 32'(pixel_index), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_frame", 32'(frame_done),  32'd0);
        check("rst_err",   32'(bit_error),   32'd0);
        rst_n = 1'b1;

        // Initial gap only synchronizes; no frame_done.
        gap(860);
        check("sync_no_frame", 32'(fd_cnt), 32'd0);

        // First pixel with exact latency check on the last falling edge.
        base = pv_cnt;
        px = 24'hA5C33C;
        send_bits(px >> 1, 23);
        din = 1'b1;
        repeat (6) @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_3clk_quiet", 32'(pixel_valid), 32'd0);
        @(negedge clk);
        check("lat_4clk_valid", 32'(pixel_valid), 32'd1);
        check("p0_data",  32'(pixel_data),  32'hA5C33C);
        check("p0_index", 32'(pixel_index), 32'd0);
        repeat (10) @(negedge clk);
        check("p0_count", 32'(pv_cnt - base), 32'd1);

        // Three pixels in a fresh frame, then one gap.
        gap(900);
        base = pv_cnt;
        send_bits(24'h000001, 24);
        send_bits(24'hFFFFFF, 24);
        send_bits(24'h800000, 24);
        fd_b = fd_cnt;
        gap(900);
        check("f3_count",  32'(pv_cnt - base), 32'd3);
        check("f3_idx0",   32'(idx_log[base]),     32'd0);
        check("f3_idx1",   32'(idx_log[base + 1]), 32'd1);
        check("f3_idx2",   32'(idx_log[base + 2]), 32'd2);
        check("f3_data0",  32'(data_log[base]),     32'h000001);
        check("f3_data1",  32'(data_log[base + 1]), 32'hFFFFFF);
        check("f3_data2",  32'(data_log[base + 2]), 32'h800000);
        check("f3_one_frame", 32'(fd_cnt - fd_b), 32'd1);
        send_bits(24'h5A5A5A, 24);
        gap(5);
        check("f3_next_idx",  32'(idx_log[base + 3]),  32'd0);
        check("f3_next_data", 32'(data_log[base + 3]), 32'h5A5A5A);

        // Short and long illegal pulses in the middle of a pixel.
        be_b = be_cnt;
        base = pv_cnt;
        send_bits(24'h000015, 5);
        send_pulse(2, 14);
        check("err_short", 32'(be_cnt - be_b), 32'd1);
        send_bits(24'h00000A, 5);
        send_pulse(25, 14);
        check("err_long", 32'(be_cnt - be_b), 32'd2);
        check("err_no_pixel", 32'(pv_cnt - base), 32'd0);
        send_bits(24'h123456, 24);
        gap(5);
        check("err_recover_cnt",  32'(pv_cnt - base), 32'd1);
        check("err_recover_data", 32'(pixel_data),  32'h123456);
        check("err_recover_idx",  32'(pixel_index), 32'd1);

        // Threshold and width boundaries: 9->0, 10->1, 3->0, 20->1.
        be_b = be_cnt;
        send_pulse(9, 14);
        send_pulse(10, 7);
        send_pulse(3, 14);
        send_pulse(20, 7);
        send_bits(24'h0ABCDE, 20);
        gap(5);
        check("bnd_data", 32'(pixel_data),  32'h5ABCDE);
        check("bnd_idx",  32'(pixel_index), 32'd2);
        check("bnd_no_err", 32'(be_cnt - be_b), 32'd0);

        // Truncated pixel ended by a gap.
        base = pv_cnt;
        fdbe_b = fdbe_cnt;
        send_bits(24'h0003FF, 10);
        gap(900);
        check("trunc_frame_err", 32'(fdbe_cnt - fdbe_b), 32'd1);
        check("trunc_no_pixel",  32'(pv_cnt - base), 32'd0);
        check("trunc_idx",       32'(pixel_index), 32'd0);

        // Reset in the middle of bit 12, then a pixel with no preceding gap.
        base = pv_cnt;
        send_bits(24'h000ABC, 12);
        din = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_data",  32'(pixel_data),  32'd0);
        check("mid_rst_valid", 32'(pixel_valid), 32'd0);
        rst_n = 1'b1;
        send_bits(24'hFFFFFF, 24);
        gap(5);
        check("post_rst_no_decode", 32'(pv_cnt - base), 32'd0);
        fd_b = fd_cnt;
        gap(860);
        check("post_rst_no_frame", 32'(fd_cnt - fd_b), 32'd0);
        send_bits(24'h0F0F0F, 24);
        gap(5);
        check("post_rst_cnt",  32'(pv_cnt - base), 32'd1);
        check("post_rst_data", 32'(pixel_data),  32'h0F0F0F);
        check("post_rst_idx",  32'(pixel_index), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
